// File: rtl/fetch_entry_queue.sv
// Fetch entry queue between the frontend and the decode stage.
// A small circular buffer with a RUN/HOLD state machine. Once an entry that
// carries a fetch fault is accepted, the queue refuses new entries until that
// faulting entry has been handed to decode, so nothing fetched after a fault
// reaches decode. A flush empties the queue and returns it to RUN.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. Ready never depends on the same-side valid. out_entry_o is only
// meaningful while out_valid_o is high. No bypass: an entry pushed into an
// empty queue is visible on the output one cycle later.

// Minimal stand-alone definition of the fetch entry type, so this block
// elaborates without the full core package.
package ariane_pkg;
   typedef struct packed {
      logic [31:0] cause;
      logic [31:0] tval;
      logic        valid;
   } exception_t;

   typedef struct packed {
      logic [31:0] address;
      logic [31:0] instruction;
      exception_t  ex;
   } fetch_entry_t;
endpackage

module fetch_entry_queue #(
   parameter int  DEPTH         = 4,
   parameter type fetch_entry_t = ariane_pkg::fetch_entry_t
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   input  fetch_entry_t             in_entry_i,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   output fetch_entry_t             out_entry_o,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     hold_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   // RUN accepts entries; HOLD waits for the recorded faulting entry to drain.
   localparam logic [0:0] RUN  = 1'b0;
   localparam logic [0:0] HOLD = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic          fault_pend_q, fault_pend_d;
   logic [PW-1:0] fault_idx_q, fault_idx_d;

   fetch_entry_t  mem_q [DEPTH];

   logic push;
   logic pop;

   // Handshake outputs; ready is forced low during reset so nothing is
   // offered before the control state is released.
   always_comb begin
      out_valid_o = (cnt_q != '0);
      in_ready_o  = (cnt_q < DEPTH_C) && (state_q == RUN) && !flush_i && !rst_i;
      out_entry_o = mem_q[rd_ptr_q];
      count_o     = cnt_q;
      hold_o      = (state_q == HOLD);
      push        = in_valid_i && in_ready_o;
      pop         = out_valid_o && out_ready_i;
   end

   // Next-state logic: flush overrides everything, otherwise pointers,
   // occupancy and the fault-hold state follow the push/pop handshakes.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      fault_pend_d = fault_pend_q;
      fault_idx_d  = fault_idx_q;

      if (flush_i) begin
         state_d      = RUN;
         cnt_d        = '0;
         rd_ptr_d     = '0;
         wr_ptr_d     = '0;
         fault_pend_d = 1'b0;
         fault_idx_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
         end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
         end

         // A push is only possible in RUN, and the recorded fault is only
         // pending in HOLD, so these two branches never fire together.
         if (push && in_entry_i.ex.valid) begin
            state_d      = HOLD;
            fault_pend_d = 1'b1;
            fault_idx_d  = wr_ptr_q;
         end
         if (pop && fault_pend_q && (rd_ptr_q == fault_idx_q)) begin
            state_d      = RUN;
            fault_pend_d = 1'b0;
         end
      end
   end

   // Control state registers with asynchronous reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= RUN;
         cnt_q        <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         fault_pend_q <= 1'b0;
         fault_idx_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         fault_pend_q <= fault_pend_d;
         fault_idx_q  <= fault_idx_d;
      end
   end

   // Entry storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_entry_i;
      end
   end

endmodule
